data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 148 ++++++++++++++
 tb/tb_data_mem_responder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Data-side memory responder: byte-maskable RAM, LED register, TX byte FIFO
// with sticky overflow, and a free-running cycle counter, all with 1-cycle read latency.
module data_mem_responder #(
    parameter int MEM_WORDS  = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic [3:0]  WriteMask,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);

    // Address decode; the byte offset never participates
    logic          wr_en;
    logic          ram_sel;
    logic          reg_sel;
    logic          leds_sel;
    logic          tx_sel;
    logic          status_sel;
    logic [AW-1:0] word_idx;
    logic          unused_addr_bits;

    assign wr_en            = MemWrite & (|WriteMask);
    assign ram_sel          = (Address[31:AW+2] == '0);
    assign reg_sel          = (Address[31:4] == 28'h0001_000);
    assign leds_sel         = reg_sel & (Address[3:2] == 2'd0);
    assign tx_sel           = reg_sel & (Address[3:2] == 2'd1);
    assign status_sel       = reg_sel & (Address[3:2] == 2'd2);
    assign word_idx         = Address[AW+1:2];
    assign unused_addr_bits = ^Address[1:0];

    // One byte-wide RAM per lane gives per-lane write enables and read-before-write
    logic [31:0] ram_rdata;
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [0:MEM_WORDS-1];
            logic [7:0] lane_q;
            always_ff @(posedge clk) begin
                if (wr_en && ram_sel && WriteMask[gi]) begin
                    lane_mem[word_idx] <= WriteData[8*gi +: 8];
                end
                lane_q <= lane_mem[word_idx];
            end
            assign ram_rdata[8*gi +: 8] = lane_q;
        end
    endgenerate

    // TX FIFO: pointers carry one extra wrap bit to tell full from empty
    logic [7:0]  fifo_mem [0:FIFO_DEPTH-1];
    logic [PW:0] wr_ptr_reg;
    logic [PW:0] rd_ptr_reg;
    logic        empty;
    logic        full;
    logic        push_req;
    logic        push;
    logic        pop;
    logic        overflow_evt;

    assign empty        = (wr_ptr_reg == rd_ptr_reg);
    assign full         = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                          (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
    assign out_valid    = ~empty;
    assign out_data     = empty ? 8'h00 : fifo_mem[rd_ptr_reg[PW-1:0]];
    assign pop          = out_valid & out_ready;
    assign push_req     = wr_en & tx_sel & WriteMask[0];
    assign push         = push_req & (~full | pop);
    assign overflow_evt = push_req & full & ~pop;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg[PW-1:0]] <= WriteData[7:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        end
    end

    // Control registers
    logic [7:0]  leds_reg;
    logic        overflow_reg;
    logic        overflow_next;
    logic [31:0] cycle_reg;
    logic [31:0] reg_rdata;
    logic [31:0] reg_rdata_reg;
    logic        ram_sel_reg;

    // A new overflow outranks a same-cycle clear so no event is ever lost
    always_comb begin
        overflow_next = overflow_reg;
        if (overflow_evt) begin
            overflow_next = 1'b1;
        end else if (wr_en && status_sel && WriteMask[0] && WriteData[2]) begin
            overflow_next = 1'b0;
        end
    end

    always_comb begin
        reg_rdata = 32'h0;
        if (reg_sel) begin
            case (Address[3:2])
                2'd0:    reg_rdata = {24'h0, leds_reg};
                2'd2:    reg_rdata = {29'h0, overflow_reg, full, empty};
                2'd3:    reg_rdata = cycle_reg;
                default: reg_rdata = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leds_reg      <= 8'h00;
            overflow_reg  <= 1'b0;
            cycle_reg     <= 32'h0;
            reg_rdata_reg <= 32'h0;
            ram_sel_reg   <= 1'b0;
        end else begin
            if (wr_en && leds_sel && WriteMask[0]) begin
                leds_reg <= WriteData[7:0];
            end
            overflow_reg  <= overflow_next;
            cycle_reg     <= cycle_reg + 32'd1;
            reg_rdata_reg <= reg_rdata;
            ram_sel_reg   <= ram_sel;
        end
    end

    // The RAM read flop has no reset, so the registered select steers reset to zero
    assign ReadData = ram_sel_reg ? ram_rdata : reg_rdata_reg;
    assign leds     = leds_reg;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: expected reads and TX bytes are queued by
// the stimulus and compared by independent monitor processes.
module tb_data_mem_responder;
    localparam logic [31:0] A_LEDS   = 32'h0001_0000;
    localparam logic [31:0] A_TX     = 32'h0001_0004;
    localparam logic [31:0] A_STATUS = 32'h0001_0008;
    localparam logic [31:0] A_CYCLE  = 32'h0001_000C;
    localparam logic [31:0] A_IDLE   = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] Address = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        MemWrite = 1'b0;
    logic [3:0]  WriteMask = 4'h0;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;

    data_mem_responder #(.MEM_WORDS(1024), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .WriteMask (WriteMask),
        .ReadData  (ReadData),
        .leds      (leds),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [31:0] exp;
        string       name;
    } rd_t;

    rd_t        rdq[$];
    logic [7:0] txq[$];
    int         cyc   = 0;
    int         tests = 0;
    int         fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end else begin
            $display("[TB] %s ok 0x%08h", name, act);
        end
    endtask

    // Read-data monitor: one cycle after the address is driven
    initial begin
        rd_t e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            while (rdq.size() != 0 && rdq[0].due <= cyc) begin
                e = rdq.pop_front();
                check(e.name, ReadData, e.exp);
            end
        end
    end

    // TX monitor: samples the handshake just before the edge that consumes it
    initial begin
        logic [7:0] b;
        forever begin
            @(negedge clk);
            #4;
            if (out_valid && out_ready) begin
                if (txq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL tx_unexpected: got byte 0x%02h required no pop", out_data);
                end else begin
                    b = txq.pop_front();
                    check("tx_byte", {24'h0, out_data}, {24'h0, b});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    // All stimulus tasks are entered just after a falling edge
    task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic we,
                         input logic [3:0] m);
        Address   = a;
        WriteData = d;
        MemWrite  = we;
        WriteMask = m;
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        drive(a, d, 1'b1, m);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        rd_t e;
        e.due = cyc + 1; e.exp = exp; e.name = name;
        rdq.push_back(e);
        drive(a, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic wr_rd(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         input logic [31:0] exp, input string name);
        rd_t e;
        e.due = cyc + 1; e.exp = exp; e.name = name;
        rdq.push_back(e);
        drive(a, d, 1'b1, m);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(A_IDLE, 32'h0, 1'b0, 4'h0);
    endtask

    task automatic tx(input logic [7:0] b, input logic accept);
        if (accept) txq.push_back(b);
        wr(A_TX, {24'h0, b}, 4'b0001);
    endtask

    initial begin
        #1;
        check("rst_readdata", ReadData, 32'h0);
        check("rst_leds", {24'h0, leds}, 32'h0);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Counter counts edges since release
        idle(3);
        rd(A_CYCLE, 32'd3, "cycle_3");
        rd(A_CYCLE, 32'd4, "cycle_4");

        // Byte-lane stores
        wr(32'h10, 32'hAABB_CCDD, 4'b1111);
        wr(32'h10, 32'h0000_00EE, 4'b0001);
        rd(32'h10, 32'hAABB_CCEE, "byte_store");
        wr(32'h10, 32'h0077_0000, 4'b0100);
        rd(32'h13, 32'hAA77_CCEE, "lane2_store_offset");
        wr(32'h10, 32'h1234_5678, 4'b0000);
        rd(32'h10, 32'hAA77_CCEE, "mask0_noop");

        // Read-during-write returns old contents
        wr(32'h20, 32'h1111_1111, 4'b1111);
        wr_rd(32'h20, 32'h2222_2222, 4'b1111, 32'h1111_1111, "collision_old");
        rd(32'h20, 32'h2222_2222, "collision_new");

        // Unmapped space
        wr(32'h0000_1010, 32'hDEAD_BEEF, 4'b1111);
        rd(32'h0000_1010, 32'h0, "unmapped_read");
        rd(32'h10, 32'hAA77_CCEE, "no_alias");

        // LED register
        wr(A_LEDS, 32'h1234_565A, 4'b0001);
        rd(A_LEDS, 32'h0000_005A, "leds_read");
        wr(A_LEDS, 32'h0000_FFFF, 4'b0010);
        rd(A_LEDS, 32'h0000_005A, "leds_mask_hi");
        check("leds_port", {24'h0, leds}, 32'h5A);
        rd(A_TX, 32'h0, "tx_read_zero");
        wr(A_CYCLE, 32'h0, 4'b1111);
        rd(A_STATUS, 32'h1, "status_empty");

        // Fill past capacity: the fifth byte is dropped
        out_ready = 1'b0;
        tx(8'h41, 1'b1);
        tx(8'h42, 1'b1);
        tx(8'h43, 1'b1);
        tx(8'h44, 1'b1);
        tx(8'h45, 1'b0);
        rd(A_STATUS, 32'h6, "status_full_ovf");
        check("head_byte", {24'h0, out_data}, 32'h41);
        out_ready = 1'b1;
        idle(6);
        rd(A_STATUS, 32'h5, "status_drained_ovf");
        wr(A_STATUS, 32'h4, 4'b0001);
        rd(A_STATUS, 32'h1, "status_ovf_clear");

        // Full with a simultaneous pop accepts the push
        out_ready = 1'b0;
        tx(8'h61, 1'b1);
        tx(8'h62, 1'b1);
        tx(8'h63, 1'b1);
        tx(8'h64, 1'b1);
        out_ready = 1'b1;
        tx(8'h55, 1'b1);
        wr(A_TX, 32'h77, 4'b0010);
        idle(6);
        rd(A_STATUS, 32'h1, "status_no_ovf");

        // Asynchronous reset with bytes queued
        out_ready = 1'b0;
        tx(8'h81, 1'b1);
        tx(8'h82, 1'b1);
        wr(A_LEDS, 32'h5A, 4'b0001);
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        check("pre_rst_leds", {24'h0, leds}, 32'h5A);
        rd(32'h10, 32'hAA77_CCEE, "pre_rst_ram");
        #2;
        reset = 1'b1;
        #1;
        txq.delete();
        check("async_out_valid", {31'h0, out_valid}, 32'h0);
        check("async_out_data", {24'h0, out_data}, 32'h0);
        check("async_leds", {24'h0, leds}, 32'h0);
        check("async_readdata", ReadData, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        idle(3);
        rd(A_CYCLE, 32'd3, "cycle_after_rst");
        rd(A_STATUS, 32'h1, "status_after_rst");
        rd(32'h10, 32'hAA77_CCEE, "ram_retained");
        idle(2);

        for (int i = 0; i < 50 && (txq.size() != 0 || rdq.size() != 0); i++) @(negedge clk);
        check("tx_pending", 32'(txq.size()), 32'h0);
        check("rd_pending", 32'(rdq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
